uart_ctrl: RTL

Memory-mapped UART controller between the CPU data bus and the serial-port datapath (byte receiver and byte transmitter). Buffers received bytes in an RX FIFO, queues CPU-written bytes in a TX FIFO, and sequences the transmitter through its start/busy handshake. Exposes three word registers and a level interrupt to the CPU.

---
 rtl/uart_ctrl_if.sv | 22 ++
 rtl/uart_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: CPU register bus plus serial receiver/transmitter handshake
interface uart_ctrl_if;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  rx_data;
  logic        rx_status;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_status;
  modport slave (
    input  mem_rd, mem_wr, addr, wdata, rx_data, rx_status, tx_status,
    output rdata, irq, tx_data, tx_start
  );
  modport master (
    output mem_rd, mem_wr, addr, wdata, rx_data, rx_status, tx_status,
    input  rdata, irq, tx_data, tx_start
  );
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped UART controller with RX/TX FIFOs, TX launch FSM and level irq
module uart_ctrl #(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  uart_ctrl_if.slave bus
);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WBUSY  = 2'd2;
  localparam logic [1:0] S_WDONE  = 2'd3;
  logic [7:0]   rx_mem_q [RX_DEPTH];
  logic [7:0]   tx_mem_q [TX_DEPTH];
  logic [RXW-1:0] rx_wp_q, rx_rp_q;
  logic [TXW-1:0] tx_wp_q, tx_rp_q;
  logic [RXW:0] rx_cnt_q, rx_cnt_d;
  logic [TXW:0] tx_cnt_q, tx_cnt_d;
  logic [1:0]   state_q, state_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic rx_prev_q, rx_ovr_q, rx_ovr_d, tx_drop_q, tx_drop_d;
  logic rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
  logic rx_fall, rx_ne, rx_full, rx_pop, rx_push;
  logic tx_ne, tx_full, tx_wr, tx_pop, tx_push, tx_idle, con_wr;
  logic [31:0] con;
  logic unused_wdata;
  assign unused_wdata = ^{bus.wdata[31:7], bus.wdata[3], bus.wdata[1:0]};
  always_comb begin
    rx_fall   = rx_prev_q & ~bus.rx_status;
    rx_ne     = rx_cnt_q != '0;
    rx_full   = rx_cnt_q == (RXW+1)'(RX_DEPTH);
    rx_pop    = bus.mem_rd & (bus.addr == 2'd1) & rx_ne;
    rx_push   = rx_fall & (~rx_full | rx_pop);
    tx_ne     = tx_cnt_q != '0;
    tx_full   = tx_cnt_q == (TXW+1)'(TX_DEPTH);
    tx_wr     = bus.mem_wr & (bus.addr == 2'd0);
    con_wr    = bus.mem_wr & (bus.addr == 2'd2);
    tx_pop    = (state_q == S_IDLE) & tx_ne & ~bus.tx_status;
    tx_push   = tx_wr & (~tx_full | tx_pop);
    tx_idle   = ~tx_ne & (state_q == S_IDLE);
    rx_ovr_d  = (rx_fall & rx_full & ~rx_pop) | (rx_ovr_q & ~(con_wr & bus.wdata[2]));
    tx_drop_d = (tx_wr & tx_full & ~tx_pop) | (tx_drop_q & ~(con_wr & bus.wdata[6]));
    rx_ie_d   = con_wr ? bus.wdata[4] : rx_ie_q;
    tx_ie_d   = con_wr ? bus.wdata[5] : tx_ie_q;
    rx_cnt_d  = rx_cnt_q + (RXW+1)'(rx_push) - (RXW+1)'(rx_pop);
    tx_cnt_d  = tx_cnt_q + (TXW+1)'(tx_push) - (TXW+1)'(tx_pop);
    tx_data_d = tx_pop ? tx_mem_q[tx_rp_q] : tx_data_q;
    state_d   = state_q == S_IDLE   ? (tx_pop ? S_LAUNCH : S_IDLE) :
                state_q == S_LAUNCH ? S_WBUSY :
                state_q == S_WBUSY  ? (bus.tx_status ? S_WDONE : S_WBUSY) :
                                      (bus.tx_status ? S_WDONE : S_IDLE);
    con = {25'b0, tx_drop_q, tx_ie_q, rx_ie_q, tx_idle, rx_ovr_q, tx_full, rx_ne};
  end
  assign bus.rdata    = bus.addr == 2'd1 ? {24'b0, rx_ne ? rx_mem_q[rx_rp_q] : 8'h00} :
                        bus.addr == 2'd2 ? con : 32'h0;
  assign bus.irq      = (rx_ie_q & rx_ne) | (tx_ie_q & tx_idle);
  assign bus.tx_start = state_q == S_LAUNCH;
  assign bus.tx_data  = tx_data_q;
  // FIFO storage carries no reset; occupancy is governed by the pointers and counts
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= bus.rx_data;
    if (tx_push) tx_mem_q[tx_wp_q] <= bus.wdata[7:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      state_q   <= S_IDLE;
      tx_data_q <= 8'h00;
      rx_prev_q <= 1'b1;
      rx_ovr_q  <= 1'b0;
      tx_drop_q <= 1'b0;
      rx_ie_q   <= 1'b0;
      tx_ie_q   <= 1'b0;
    end else begin
      rx_wp_q   <= rx_push ? rx_wp_q + RXW'(1) : rx_wp_q;
      rx_rp_q   <= rx_pop ? rx_rp_q + RXW'(1) : rx_rp_q;
      rx_cnt_q  <= rx_cnt_d;
      tx_wp_q   <= tx_push ? tx_wp_q + TXW'(1) : tx_wp_q;
      tx_rp_q   <= tx_pop ? tx_rp_q + TXW'(1) : tx_rp_q;
      tx_cnt_q  <= tx_cnt_d;
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      rx_prev_q <= bus.rx_status;
      rx_ovr_q  <= rx_ovr_d;
      tx_drop_q <= tx_drop_d;
      rx_ie_q   <= rx_ie_d;
      tx_ie_q   <= tx_ie_d;
    end
  end
endmodule
